// File: rtl/apb_cfg_arbiter.sv
// apb_cfg_arbiter: two-requester (host=0, loader=1) round-robin front end
// driving a single APB master. One transfer at a time: IDLE -> SETUP ->
// ACCESS -> RESP, with an ACCESS-phase timeout and a bad-select shortcut
// that answers with an error without touching the bus.
module apb_cfg_arbiter #(
  parameter int ADDR_WIDTH  = 7,
  parameter int PDATA_WIDTH = 32,
  parameter int COMP        = 5,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  // host requester (index 0)
  input  logic                   h_req,
  input  logic                   h_write,
  input  logic [COMP-1:0]        h_sel,
  input  logic [ADDR_WIDTH-1:0]  h_addr,
  input  logic [PDATA_WIDTH-1:0] h_wdata,
  output logic                   h_gnt,
  output logic                   h_done,
  output logic                   h_err,
  output logic [PDATA_WIDTH-1:0] h_rdata,
  // loader requester (index 1)
  input  logic                   l_req,
  input  logic                   l_write,
  input  logic [COMP-1:0]        l_sel,
  input  logic [ADDR_WIDTH-1:0]  l_addr,
  input  logic [PDATA_WIDTH-1:0] l_wdata,
  output logic                   l_gnt,
  output logic                   l_done,
  output logic                   l_err,
  output logic [PDATA_WIDTH-1:0] l_rdata,
  // APB master
  output logic [COMP-1:0]        PSELx,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_WIDTH-1:0]  PADDR,
  output logic [PDATA_WIDTH-1:0] PWDATA,
  input  logic [PDATA_WIDTH-1:0] PRDATA,
  input  logic                   PREADY,
  // status
  output logic                   busy,
  output logic                   owner
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // Counter must be able to hold TIMEOUT itself so saturation is representable.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  state_t                   state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     write_q, write_d;
  logic [COMP-1:0]          sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [PDATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [1:0]               gnt_q, gnt_d;
  logic [1:0]               done_q, done_d;
  logic                     err_q, err_d;
  logic [PDATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic any_req;
  logic win;
  logic sel_ok;
  logic bus_act;

  // Arbitration: on a tie the requester that did not win last time goes next;
  // a lone requester always wins.
  always_comb begin
    any_req = h_req | l_req;
    win     = (h_req & l_req) ? ~owner_q : ~h_req;
  end

  // Latched select must be exactly one-hot for the transfer to reach the bus.
  always_comb begin
    sel_ok  = $onehot(sel_q);
    bus_act = ((state_q == SETUP) || (state_q == ACCESS)) && sel_ok;
  end

  // Next-state and result computation for the transfer FSM.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    write_d = write_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    err_d   = err_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          write_d      = win ? l_write : h_write;
          sel_d        = win ? l_sel   : h_sel;
          addr_d       = win ? l_addr  : h_addr;
          wdata_d      = win ? l_wdata : h_wdata;
          gnt_d[win]   = 1'b1;
          owner_d      = win;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        if (sel_ok) begin
          // fresh timeout window for every access phase
          cnt_d   = '0;
          state_d = ACCESS;
        end else begin
          // bad select: answer with an error, never touch the bus
          done_d[owner_q] = 1'b1;
          err_d           = 1'b1;
          rdata_d         = '0;
          state_d         = RESP;
        end
      end
      ACCESS: begin
        if (PREADY) begin
          done_d[owner_q] = 1'b1;
          err_d           = 1'b0;
          rdata_d         = write_q ? '0 : PRDATA;
          state_d         = RESP;
        end else if (cnt_q == CNT_LAST) begin
          // this was the last permitted wait cycle: abort
          done_d[owner_q] = 1'b1;
          err_d           = 1'b1;
          rdata_d         = '0;
          state_d         = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        err_d   = 1'b0;
        rdata_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      write_q <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode: bus signals only live while a valid transfer is on the bus;
  // responses are only non-zero for the requester being answered.
  always_comb begin
    PSELx   = bus_act ? sel_q : '0;
    PENABLE = (state_q == ACCESS) && sel_ok;
    PWRITE  = bus_act & write_q;
    PADDR   = bus_act ? addr_q  : '0;
    PWDATA  = bus_act ? wdata_q : '0;

    h_gnt   = gnt_q[0];
    l_gnt   = gnt_q[1];
    h_done  = done_q[0];
    l_done  = done_q[1];
    h_err   = done_q[0] & err_q;
    l_err   = done_q[1] & err_q;
    h_rdata = done_q[0] ? rdata_q : '0;
    l_rdata = done_q[1] ? rdata_q : '0;

    busy    = (state_q != IDLE);
    owner   = owner_q;
  end

endmodule
